// File: rtl/ninjakun_irq_controller_if.sv
// Bundle of the interrupt generator's bus signals: tick enable, video blank,
// per-channel enable/acknowledge/overrun-clear in; IRQ, overrun and timer count out.
interface ninjakun_irq_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 14
);
    logic             ce;
    logic             vblk;
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   ack;
    logic [NCH-1:0]   miss_clr;
    logic [NCH-1:0]   irq;
    logic [NCH-1:0]   miss;
    logic [CNT_W-1:0] cnt;

    // Driver side: video timing, CPU acknowledge logic, control registers
    modport master (
        output ce, vblk, en, ack, miss_clr,
        input  irq, miss, cnt
    );

    // Interrupt generator side
    modport slave (
        input  ce, vblk, en, ack, miss_clr,
        output irq, miss, cnt
    );
endinterface

// File: rtl/ninjakun_irq_controller.sv
// N-channel Z80 interrupt generator. Each channel fires either on the VBLK
// rising edge or at a fixed phase of a periodic timer that is resynchronised
// by VBLK. Requests are held until acknowledged; an event arriving while a
// request is still pending sets a sticky overrun flag.
module ninjakun_irq_controller #(
    parameter int unsigned          NCH    = 2,
    parameter int unsigned          CNT_W  = 14,
    parameter int unsigned          PERIOD = 12500,
    parameter logic [NCH-1:0]       MODE   = 2'b10,
    parameter logic [NCH*CNT_W-1:0] PHASE  = {14'd1, 14'd0}
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ninjakun_irq_if.slave irq_bus
);

    // Last count before the timer wraps back to zero
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    genvar gi;

    // Parameter sanity: caught while elaborating, never in hardware
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("ninjakun_irq_controller: NCH must be 1..8");
    end
    if (PERIOD < 1 || longint'(PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_period
        $error("ninjakun_irq_controller: PERIOD must be 1..2**CNT_W");
    end

    logic             hist_q, hist_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   irq_q, irq_d;
    logic [NCH-1:0]   miss_q, miss_d;
    logic [NCH-1:0]   ev;
    logic [NCH-1:0]   ge;
    logic [NCH-1:0]   miss_set;
    logic             vbe;
    logic             wrap;

    // VBLK rising edge, judged against the level seen on the previous tick
    assign vbe  = irq_bus.ce & irq_bus.vblk & ~hist_q;
    assign wrap = (cnt_q == LAST);

    // VBLK history and timer advance only on tick; a VBLK edge resyncs the timer ahead of the wrap
    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (irq_bus.ce) begin
            hist_d = irq_bus.vblk;
            if (vbe || wrap) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Per-channel event source, chosen at elaboration; timer phases use the count before this tick's update
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        if (MODE[gi]) begin : g_timer
            if (32'(PHASE[gi*CNT_W +: CNT_W]) >= PERIOD) begin : g_bad_phase
                $error("ninjakun_irq_controller: PHASE slice must be below PERIOD");
            end
            assign ev[gi] = irq_bus.ce & (cnt_q == PHASE[gi*CNT_W +: CNT_W]);
        end else begin : g_vblk
            assign ev[gi] = vbe;
        end
    end

    // A new event always (re)asserts IRQ, winning over a same-cycle ACK so it is never lost;
    // overrun is flagged only when the event lands on a request that stays pending
    assign ge       = ev & irq_bus.en;
    assign miss_set = ge & irq_q & ~irq_bus.ack;
    assign irq_d    = ge | (irq_q & ~irq_bus.ack);
    assign miss_d   = miss_set | (miss_q & ~irq_bus.miss_clr);

    // State registers; VBLK history resets high so a blank already active at release is not an edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= 1'b1;
            cnt_q  <= '0;
            irq_q  <= '0;
            miss_q <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
            irq_q  <= irq_d;
            miss_q <= miss_d;
        end
    end

    assign irq_bus.irq  = irq_q;
    assign irq_bus.miss = miss_q;
    assign irq_bus.cnt  = cnt_q;

endmodule

// File: tb/tb_ninjakun_irq_controller.sv
// Bench for the interrupt generator: two instances (default 2-channel and a
// 4-channel variant) checked every clock against an event-level reference model,
// plus directed checks of the documented timing cases.
module tb_ninjakun_irq_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0;
    logic vblk = 1'b1;
    logic [7:0] en_a = '0, ack_a = '0, clr_a = '0;
    logic [7:0] en_b = '0, ack_b = '0, clr_b = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ninjakun_irq_if #(.NCH(2), .CNT_W(14)) bus_a();
    ninjakun_irq_if #(.NCH(4), .CNT_W(14)) bus_b();

    assign bus_a.ce = ce;
    assign bus_a.vblk = vblk;
    assign bus_a.en = en_a[1:0];
    assign bus_a.ack = ack_a[1:0];
    assign bus_a.miss_clr = clr_a[1:0];
    assign bus_b.ce = ce;
    assign bus_b.vblk = vblk;
    assign bus_b.en = en_b[3:0];
    assign bus_b.ack = ack_b[3:0];
    assign bus_b.miss_clr = clr_b[3:0];

    ninjakun_irq_controller #(
        .NCH(2), .CNT_W(14), .PERIOD(12500), .MODE(2'b10), .PHASE({14'd1, 14'd0})
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .irq_bus(bus_a)
    );

    ninjakun_irq_controller #(
        .NCH(4), .CNT_W(14), .PERIOD(100), .MODE(4'b1110),
        .PHASE({14'd75, 14'd50, 14'd25, 14'd0})
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .irq_bus(bus_b)
    );

    // Reference model: timer as "CE ticks since last resync, modulo PERIOD"
    int       m_period[2];
    int       m_nch[2];
    bit [7:0] m_mode[2];
    int       m_phase[2][8];
    int       m_ticks[2];
    bit       m_hist[2];
    bit [7:0] m_irq[2];
    bit [7:0] m_miss[2];

    function automatic int model_cnt(input int m);
        return m_ticks[m] % m_period[m];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ticks[m] = 0;
            m_hist[m]  = 1'b1;
            m_irq[m]   = '0;
            m_miss[m]  = '0;
        end
    endtask

    task automatic model_step(input int m, input bit ce_v, input bit vblk_v,
                              input bit [7:0] en_v, input bit [7:0] ack_v, input bit [7:0] clr_v);
        bit vbe;
        bit ev;
        bit ge;
        bit overrun;
        int cur;
        vbe = ce_v && vblk_v && !m_hist[m];
        cur = model_cnt(m);
        for (int ch = 0; ch < m_nch[m]; ch++) begin
            ev = m_mode[m][ch] ? (ce_v && cur == m_phase[m][ch]) : vbe;
            ge = ev && en_v[ch];
            overrun = ge && m_irq[m][ch] && !ack_v[ch];
            if (ge) m_irq[m][ch] = 1'b1;
            else if (ack_v[ch]) m_irq[m][ch] = 1'b0;
            if (overrun) m_miss[m][ch] = 1'b1;
            else if (clr_v[ch]) m_miss[m][ch] = 1'b0;
        end
        if (ce_v) begin
            m_ticks[m] = vbe ? 0 : m_ticks[m] + 1;
            m_hist[m]  = vblk_v;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("a_state", {bus_a.irq, bus_a.miss, bus_a.cnt},
              {m_irq[0][1:0], m_miss[0][1:0], 14'(model_cnt(0))});
        check("b_state", {bus_b.irq, bus_b.miss, bus_b.cnt},
              {m_irq[1][3:0], m_miss[1][3:0], 14'(model_cnt(1))});
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1 ns later
    task automatic cyc();
        if (!rst) begin
            model_step(0, ce, vblk, en_a, ack_a, clr_a);
            model_step(1, ce, vblk, en_b, ack_b, clr_b);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asynchronous reset between edges; outputs must clear before the next clock
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("a_rst_async", {bus_a.irq, bus_a.miss, bus_a.cnt}, 18'd0);
        check("b_rst_async", {bus_b.irq, bus_b.miss, bus_b.cnt}, 22'd0);
        vblk = 1'b1;
        repeat (4) begin
            ce = 1'($urandom_range(0, 1));
            cyc();
        end
        rst = 1'b0;
    endtask

    task automatic run_a_to(input int target);
        int guard;
        guard = 0;
        while (model_cnt(0) != target && guard < 20000) begin
            cyc();
            guard++;
        end
    endtask

    int rise1[4];
    int rise2[4];

    initial begin
        m_period[0] = 12500; m_nch[0] = 2; m_mode[0] = 8'b0000_0010;
        m_phase[0][0] = 0;   m_phase[0][1] = 1;
        m_period[1] = 100;   m_nch[1] = 4; m_mode[1] = 8'b0000_1110;
        m_phase[1][0] = 0;   m_phase[1][1] = 25; m_phase[1][2] = 50; m_phase[1][3] = 75;
        for (int ch = 2; ch < 8; ch++) m_phase[0][ch] = 0;
        for (int ch = 4; ch < 8; ch++) m_phase[1][ch] = 0;
        model_reset();

        // Power-on reset with VBLK high and CE running
        repeat (3) begin
            ce = 1'($urandom_range(0, 1));
            cyc();
        end
        rst = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) vblk = ~vblk;
            if ($urandom_range(0, 63) == 0) en_a = 8'($urandom);
            if ($urandom_range(0, 63) == 0) en_b = 8'($urandom);
            ack_a = 8'($urandom & $urandom);
            ack_b = 8'($urandom & $urandom);
            clr_a = 8'($urandom & $urandom & $urandom);
            clr_b = 8'($urandom & $urandom & $urandom);
            cyc();
        end
        ack_a = '0; ack_b = '0; clr_a = '0; clr_b = '0;
        en_a = 8'h03; en_b = 8'h0F;
        do_reset();

        // VBLK already high at release: no edge until it falls and rises again
        ce = 1'b1;
        repeat (5) cyc();
        check("a_no_edge_after_rst", bus_a.irq[0], 1'b0);
        ce = 1'b0; ack_a = 8'h03; cyc(); ack_a = '0;
        check("a_ack_all", bus_a.irq, 2'b00);
        ce = 1'b1; vblk = 1'b0; cyc();
        vblk = 1'b1; cyc();
        check("a_vbe_irq", bus_a.irq, 2'b01);
        check("a_vbe_cnt", bus_a.cnt, 14'd0);
        cyc();
        check("a_tick1_irq", bus_a.irq, 2'b01);
        cyc();
        check("a_tick2_irq", bus_a.irq, 2'b11);
        check("a_tick2_cnt", bus_a.cnt, 14'd2);

        // ACK with no event drops the request one clock later
        ce = 1'b0; ack_a = 8'h01; cyc(); ack_a = '0;
        check("a_ack0", bus_a.irq, 2'b10);

        // Second timer event on an unacked request -> overrun
        ce = 1'b1;
        run_a_to(1);
        cyc();
        check("a_overrun_miss", bus_a.miss, 2'b10);
        check("a_overrun_irq", bus_a.irq, 2'b10);
        ce = 1'b0; clr_a = 8'h02; cyc(); clr_a = '0;
        check("a_missclr_miss", bus_a.miss, 2'b00);
        check("a_missclr_irq", bus_a.irq, 2'b10);

        // ACK coinciding with an event: request stays, no overrun
        ce = 1'b1;
        run_a_to(1);
        ack_a = 8'h02; cyc(); ack_a = '0;
        check("a_ack_vs_set_irq", bus_a.irq, 2'b10);
        check("a_ack_vs_set_miss", bus_a.miss, 2'b00);

        // Disabled channel discards its event; re-enabled it fires again
        ce = 1'b0; ack_a = 8'h02; cyc(); ack_a = '0;
        check("a_ack1", bus_a.irq, 2'b00);
        ce = 1'b1; en_a = 8'h01;
        run_a_to(1);
        cyc();
        check("a_dis_irq", bus_a.irq, 2'b00);
        check("a_dis_miss", bus_a.miss, 2'b00);
        en_a = 8'h03;
        run_a_to(1);
        cyc();
        check("a_reen_irq", bus_a.irq, 2'b10);

        // 4-channel phase sequence after a VBLK resync, across one wrap
        for (int ch = 0; ch < 4; ch++) begin
            rise1[ch] = -1;
            rise2[ch] = -1;
        end
        ce = 1'b1; vblk = 1'b0; en_b = 8'h0F;
        repeat (3) cyc();
        ce = 1'b0; ack_b = 8'h0F; cyc(); ack_b = '0;
        check("b_cleared", bus_b.irq, 4'b0000);
        ce = 1'b1; vblk = 1'b1; cyc();
        check("b_vbe_irq", bus_b.irq, 4'b0001);
        check("b_vbe_cnt", bus_b.cnt, 14'd0);
        for (int k = 1; k <= 160; k++) begin
            ack_b = (k == 90) ? 8'h0E : 8'h00;
            cyc();
            for (int ch = 1; ch < 4; ch++) begin
                if (k < 90 && rise1[ch] < 0 && bus_b.irq[ch]) rise1[ch] = k;
                if (k > 90 && rise2[ch] < 0 && bus_b.irq[ch]) rise2[ch] = k;
            end
        end
        ack_b = '0;
        check("b_rise_ch1", rise1[1], 26);
        check("b_rise_ch2", rise1[2], 51);
        check("b_rise_ch3", rise1[3], 76);
        check("b_wrap_ch1", rise2[1], 126);
        check("b_wrap_ch2", rise2[2], 151);

        // Mid-sequence reset clears every output at once
        do_reset();
        ce = 1'b1;
        repeat (10) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
